ufpu_result_queue: RTL and testbench

//  Downstream stage of the ufpu. Captures each ufpu result bit vector and buffers it in a small FIFO.
//  At enqueue, each vector is summarised into a resource id, an id-valid flag and a popcount.

---
 rtl/ufpu_pkg.sv | 16 +
 rtl/ufpu_result_queue_if.sv | 28 ++
 rtl/vec_summarize.sv | 24 ++
 rtl/ufpu_result_queue.sv | 107 ++++++++++
 tb/tb_ufpu_result_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ufpu_pkg.sv
// Shared ufpu types: result vector geometry and the buffered result entry.
package ufpu_pkg;

  localparam int unsigned BIT_VEC_SIZE     = 64;
  localparam int unsigned BIT_VEC_SIZE_LOG = 6;
  localparam int unsigned COUNT_W          = BIT_VEC_SIZE_LOG + 1;
  localparam int unsigned STAT_W           = 16;

  typedef struct packed {
    logic [BIT_VEC_SIZE-1:0]     vec;
    logic [BIT_VEC_SIZE_LOG-1:0] id;
    logic                        id_valid;
    logic [COUNT_W-1:0]          count;
  } result_entry_t;

endpackage

// File: rtl/ufpu_result_queue_if.sv
// Bus between the ufpu, the result queue and the scheduler egress / stats reader.
interface ufpu_result_queue_if;
  import ufpu_pkg::*;

  logic [BIT_VEC_SIZE-1:0]     in_vec;
  logic                        valid_in;
  logic                        ready_in;
  logic [BIT_VEC_SIZE-1:0]     out_vec;
  logic [BIT_VEC_SIZE_LOG-1:0] out_id;
  logic                        out_id_valid;
  logic [COUNT_W-1:0]          out_count;
  logic                        valid_out;
  logic                        almost_full;
  logic                        overflow;
  logic [BIT_VEC_SIZE_LOG-1:0] stat_idx;
  logic [STAT_W-1:0]           stat_cnt;

  modport master (
    output in_vec, valid_in, ready_in, stat_idx,
    input  out_vec, out_id, out_id_valid, out_count, valid_out, almost_full, overflow, stat_cnt
  );

  modport slave (
    input  in_vec, valid_in, ready_in, stat_idx,
    output out_vec, out_id, out_id_valid, out_count, valid_out, almost_full, overflow, stat_cnt
  );

endinterface

// File: rtl/vec_summarize.sv
// Combinational summary of a result vector: lowest set bit, one-hot flag, popcount.
module vec_summarize
  import ufpu_pkg::*;
(
  input  logic [BIT_VEC_SIZE-1:0]     vec,
  output logic [BIT_VEC_SIZE_LOG-1:0] id,
  output logic                        id_valid,
  output logic [COUNT_W-1:0]          count
);

  always_comb begin
    id    = '0;
    count = '0;
    // Scan high to low so the lowest set bit wins.
    for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
      if (vec[i]) id = BIT_VEC_SIZE_LOG'(i);
    end
    for (int i = 0; i < BIT_VEC_SIZE; i++) begin
      count = count + COUNT_W'(vec[i]);
    end
    id_valid = (count == COUNT_W'(1));
  end

endmodule

// File: rtl/ufpu_result_queue.sv
// ufpu result FIFO with per-entry summary, FWFT egress and early almost_full.
// Optional per-id pop statistics are built when UFPU_SEL_STATS_EN is defined.
module ufpu_result_queue
  import ufpu_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DEPTH_LOG = 2
) (
  input logic                 clk,
  input logic                 rst,
  ufpu_result_queue_if.slave  bus
);

  localparam int unsigned PTR_W = DEPTH_LOG;
  localparam int unsigned OCC_W = DEPTH_LOG + 1;

  result_entry_t in_entry;
  result_entry_t mem [DEPTH];
  result_entry_t head_q, head_next;

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [OCC_W-1:0] occ, occ_next;
  logic             valid_q, af_q, ovf_q;
  logic             full, pop, push, drop;

  logic [BIT_VEC_SIZE_LOG-1:0] sum_id;
  logic                        sum_id_valid;
  logic [COUNT_W-1:0]          sum_count;

  vec_summarize u_summarize (
    .vec      (bus.in_vec),
    .id       (sum_id),
    .id_valid (sum_id_valid),
    .count    (sum_count)
  );

  assign in_entry = '{vec: bus.in_vec, id: sum_id, id_valid: sum_id_valid, count: sum_count};

  // Next-state control; the head is precomputed so every egress output is a flop.
  always_comb begin
    full     = (occ == OCC_W'(DEPTH));
    pop      = valid_q & bus.ready_in;
    push     = bus.valid_in & (~full | pop);
    drop     = bus.valid_in & full & ~pop;
    rd_next  = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_next  = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    occ_next = occ;
    if (push && !pop)      occ_next = occ + OCC_W'(1);
    else if (pop && !push) occ_next = occ - OCC_W'(1);
    head_next = '0;
    // The new head is the incoming entry only when it lands in the slot being read next.
    if (occ_next != '0) head_next = (push && (rd_next == wr_ptr)) ? in_entry : mem[rd_next];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rd_ptr  <= rd_next;
      wr_ptr  <= wr_next;
      occ     <= occ_next;
      head_q  <= head_next;
      valid_q <= (occ_next != '0);
      af_q    <= ((OCC_W'(DEPTH) - occ_next) <= OCC_W'(2));
      ovf_q   <= ovf_q | drop;
    end
  end

  // Data array carries no reset; validity is tracked by the control state.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  assign bus.out_vec      = head_q.vec;
  assign bus.out_id       = head_q.id;
  assign bus.out_id_valid = head_q.id_valid;
  assign bus.out_count    = head_q.count;
  assign bus.valid_out    = valid_q;
  assign bus.almost_full  = af_q;
  assign bus.overflow     = ovf_q;

`ifdef UFPU_SEL_STATS_EN
  logic [STAT_W-1:0] stat_q [BIT_VEC_SIZE];

  // Saturating per-id count of one-hot pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BIT_VEC_SIZE; i++) stat_q[i] <= '0;
    end else if (pop && head_q.id_valid && (stat_q[head_q.id] != {STAT_W{1'b1}})) begin
      stat_q[head_q.id] <= stat_q[head_q.id] + STAT_W'(1);
    end
  end

  assign bus.stat_cnt = stat_q[bus.stat_idx];
`else
  logic unused_stat_idx;
  assign unused_stat_idx = ^bus.stat_idx;
  assign bus.stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_ufpu_result_queue.sv
// Self-checking bench for ufpu_result_queue: directed table, corner sequences, random vs queue model.
module tb_ufpu_result_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ufpu_result_queue_if bus ();

  ufpu_result_queue #(.DEPTH(DEPTH), .DEPTH_LOG(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain queue of vectors plus sticky overflow and per-id pop counts.
  logic [63:0] mq[$];
  bit          m_ovf;
  int unsigned m_stat [64];

  typedef struct packed {
    logic        v;
    logic [63:0] vec;
    logic        rdy;
    logic        e_valid;
    logic [5:0]  e_id;
    logic        e_idv;
    logic [6:0]  e_cnt;
    logic        e_af;
    logic        e_ovf;
  } row_t;

  row_t tbl [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] low_id(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return 6'(i);
    return 6'd0;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ovf = 0;
    for (int i = 0; i < 64; i++) m_stat[i] = 0;
  endtask

  task automatic check_model(input string tag);
    logic [63:0] h;
    int unsigned sz;
    logic [15:0] es;
    sz = mq.size();
    h  = (sz != 0) ? mq[0] : 64'd0;
`ifdef UFPU_SEL_STATS_EN
    es = 16'(m_stat[bus.stat_idx]);
`else
    es = 16'd0;
`endif
    chk({tag, ".vec"},   bus.out_vec, h);
    chk({tag, ".id"},    64'(bus.out_id), 64'(low_id(h)));
    chk({tag, ".idv"},   64'(bus.out_id_valid), 64'($countones(h) == 1));
    chk({tag, ".cnt"},   64'(bus.out_count), 64'($countones(h)));
    chk({tag, ".valid"}, 64'(bus.valid_out), 64'(sz != 0));
    chk({tag, ".af"},    64'(bus.almost_full), 64'((DEPTH - int'(sz)) <= 2));
    chk({tag, ".ovf"},   64'(bus.overflow), 64'(m_ovf));
    chk({tag, ".stat"},  64'(bus.stat_cnt), 64'(es));
  endtask

  // Drive one cycle (inputs set 1 time unit after an edge), advance model, check after the edge.
  task automatic cycle(input logic v, input logic [63:0] vec, input logic rdy, input string tag);
    bit pop, full;
    logic [63:0] p;
    bus.valid_in = v;
    bus.in_vec   = vec;
    bus.ready_in = rdy;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    if (pop) begin
      p = mq.pop_front();
      if ($countones(p) == 1 && m_stat[low_id(p)] < 16'hFFFF) m_stat[low_id(p)]++;
    end
    if (v) begin
      if (!full || pop) mq.push_back(vec);
      else m_ovf = 1;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Async reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, 64'(bus.valid_out), 64'd0);
    chk({tag, ".rst_af"},    64'(bus.almost_full), 64'd0);
    chk({tag, ".rst_ovf"},   64'(bus.overflow), 64'd0);
    chk({tag, ".rst_vec"},   bus.out_vec, 64'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_vec();
    case ($urandom_range(0, 3))
      0:       return 64'd0;
      1:       return 64'd1 << $urandom_range(0, 63);
      2:       return {$urandom, $urandom};
      default: return (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.in_vec   = '0;
    bus.stat_idx = '0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    //            v     vec                     rdy   valid id     idv   cnt    af    ovf
    tbl[0]  = '{1'b1, 64'h0000_0000_0000_0100, 1'b1, 1'b1, 6'd8, 1'b1, 7'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 64'h0000_0000_0000_00F0, 1'b0, 1'b1, 6'd4, 1'b0, 7'd4, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 64'h0,                   1'b0, 1'b1, 6'd4, 1'b0, 7'd4, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 6'd0, 1'b0, 7'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 64'h2,                   1'b0, 1'b1, 6'd1, 1'b1, 7'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 64'h4,                   1'b0, 1'b1, 6'd1, 1'b1, 7'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 64'h8,                   1'b0, 1'b1, 6'd1, 1'b1, 7'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 64'h10,                  1'b0, 1'b1, 6'd1, 1'b1, 7'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 64'h20,                  1'b0, 1'b1, 6'd1, 1'b1, 7'd1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 64'h0,                   1'b1, 1'b1, 6'd2, 1'b1, 7'd1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 64'h0,                   1'b1, 1'b1, 6'd3, 1'b1, 7'd1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 64'h0,                   1'b1, 1'b1, 6'd4, 1'b1, 7'd1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 64'h0,                   1'b1, 1'b0, 6'd0, 1'b0, 7'd0, 1'b0, 1'b1};

    for (int r = 0; r < 15; r++) begin
      cycle(tbl[r].v, tbl[r].vec, tbl[r].rdy, $sformatf("tbl%0d", r));
      chk($sformatf("tbl%0d.valid", r), 64'(bus.valid_out),    64'(tbl[r].e_valid));
      chk($sformatf("tbl%0d.id", r),    64'(bus.out_id),       64'(tbl[r].e_id));
      chk($sformatf("tbl%0d.idv", r),   64'(bus.out_id_valid), 64'(tbl[r].e_idv));
      chk($sformatf("tbl%0d.cnt", r),   64'(bus.out_count),    64'(tbl[r].e_cnt));
      chk($sformatf("tbl%0d.af", r),    64'(bus.almost_full),  64'(tbl[r].e_af));
      chk($sformatf("tbl%0d.ovf", r),   64'(bus.overflow),     64'(tbl[r].e_ovf));
    end

    // Full FIFO with simultaneous push and pop
    do_reset("full_pp");
    for (int k = 1; k <= 4; k++) cycle(1'b1, 64'd1 << k, 1'b0, "full_fill");
    cycle(1'b1, 64'd1 << 9, 1'b1, "full_pp");
    chk("full_pp.ovf", 64'(bus.overflow), 64'd0);
    chk("full_pp.head2", 64'(bus.out_id), 64'd2);
    cycle(1'b0, 64'd0, 1'b1, "full_d");
    chk("full_pp.head3", 64'(bus.out_id), 64'd3);
    cycle(1'b0, 64'd0, 1'b1, "full_d");
    chk("full_pp.head4", 64'(bus.out_id), 64'd4);
    cycle(1'b0, 64'd0, 1'b1, "full_d");
    chk("full_pp.head9", 64'(bus.out_id), 64'd9);
    cycle(1'b0, 64'd0, 1'b1, "full_d");
    chk("full_pp.empty", 64'(bus.valid_out), 64'd0);

    // Async reset mid-stream with three entries queued
    for (int k = 1; k <= 3; k++) cycle(1'b1, 64'd1 << k, 1'b0, "ar_fill");
    chk("ar.af_before", 64'(bus.almost_full), 64'd1);
    do_reset("ar");
    cycle(1'b1, 64'd1 << 7, 1'b0, "ar_push7");
    chk("ar.head7", 64'(bus.out_id), 64'd7);
    cycle(1'b0, 64'd0, 1'b1, "ar_pop");
    chk("ar.alone", 64'(bus.valid_out), 64'd0);

    // Stats: three one-hot id-3 pops and one multi-bit vector with lowest bit 3
    do_reset("stats");
    bus.stat_idx = 6'd3;
    cycle(1'b1, 64'h8,  1'b1, "st");
    cycle(1'b1, 64'h8,  1'b1, "st");
    cycle(1'b1, 64'h8,  1'b1, "st");
    cycle(1'b1, 64'h18, 1'b1, "st");
    cycle(1'b0, 64'h0,  1'b1, "st");
`ifdef UFPU_SEL_STATS_EN
    chk("stats.idx3", 64'(bus.stat_cnt), 64'd3);
`else
    chk("stats.idx3", 64'(bus.stat_cnt), 64'd0);
`endif
    bus.stat_idx = 6'd4;
    #1;
    chk("stats.idx4", 64'(bus.stat_cnt), 64'd0);

    // Randomized traffic against the queue model
    do_reset("rand");
    for (int n = 0; n < 3000; n++) begin
      bus.stat_idx = 6'($urandom_range(0, 63));
      cycle(1'($urandom_range(0, 99) < 60), rand_vec(), 1'($urandom_range(0, 99) < 55), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
